// File: rtl/pipe_ctrl.sv
// Pipeline control unit: sole driver of the per-stage stall vector.
// Merges ID/EX/MEM stall requests by priority, sequences the exception flush
// (registered flush + new_pc), and keeps a saturating stall-cycle counter plus
// a sticky watchdog that fires after TIMEOUT_CYC consecutive stalled cycles.
// stall bit map: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = hold.

module pipe_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1024,  // >= 2
  parameter int unsigned FLUSH_CYC   = 1      // 1..15
) (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active-low
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  // Run counter only has to reach TIMEOUT_CYC, then it holds.
  localparam int unsigned     RunW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [RunW-1:0] RunMax    = RunW'(TIMEOUT_CYC);
  localparam logic [3:0]      FlushLoad = 4'(FLUSH_CYC - 1);

  // Stop masks: a stalled stage also holds every stage upstream of it.
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallNone = 6'b000000;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [3:0]      flush_cnt_q, flush_cnt_d;
  logic [31:0]     new_pc_q, new_pc_d;
  logic [31:0]     stall_cycles_q, stall_cycles_d;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  logic            stall_timeout_q, stall_timeout_d;
  logic            stall_any;

  // Stall decode: same-cycle, priority MEM > EX > ID; flush and reset force zero
  // so the bus is defined even while the requests are unknown.
  always_comb begin
    stall = StallNone;
    if (!rst || (state_q == StFlush)) begin
      stall = StallNone;
    end else if (stallreq_mem) begin
      stall = StallMem;
    end else if (stallreq_ex) begin
      stall = StallEx;
    end else if (stallreq_id) begin
      stall = StallId;
    end
  end

  assign stall_any = |stall;

  // Flush FSM next state: capture target on entry, ignore requests while flushing.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;
    unique case (state_q)
      StRun: begin
        if (flush_req) begin
          state_d     = StFlush;
          flush_cnt_d = FlushLoad;
          new_pc_d    = flush_pc;
        end
      end
      StFlush: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = StRun;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  // Statistics and watchdog next state; both counters saturate instead of wrapping.
  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    run_cnt_d       = run_cnt_q;
    stall_timeout_d = stall_timeout_q;
    if (stall_any && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (!stall_any) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != RunMax) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
    // Sticky: only reset clears it.
    if (stall_any && (run_cnt_d == RunMax)) begin
      stall_timeout_d = 1'b1;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StRun;
      flush_cnt_q     <= 4'd0;
      new_pc_q        <= 32'd0;
      stall_cycles_q  <= 32'd0;
      run_cnt_q       <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      new_pc_q        <= new_pc_d;
      stall_cycles_q  <= stall_cycles_d;
      run_cnt_q       <= run_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  // flush is a decode of the registered state, so it rises the cycle after flush_req.
  assign flush         = (state_q == StFlush);
  assign new_pc        = new_pc_q;
  assign stall_cycles  = stall_cycles_q;
  assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances share stimulus, one with a
// single-cycle flush and one with a three-cycle flush, both with an 8-cycle watchdog.

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem, flush_req;
  logic [31:0] flush_pc;

  logic [5:0]  a_stall, b_stall;
  logic        a_flush, b_flush, a_tmo, b_tmo;
  logic [31:0] a_new_pc, b_new_pc, a_cyc, b_cyc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT_CYC(8), .FLUSH_CYC(1)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (a_stall),
    .flush        (a_flush),
    .new_pc       (a_new_pc),
    .stall_cycles (a_cyc),
    .stall_timeout(a_tmo)
  );

  pipe_ctrl #(.TIMEOUT_CYC(8), .FLUSH_CYC(3)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (b_stall),
    .flush        (b_flush),
    .new_pc       (b_new_pc),
    .stall_cycles (b_cyc),
    .stall_timeout(b_tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    flush_req    = 1'b0;
    flush_pc     = 32'd0;
  endtask

  // Mid-cycle reset pulse with quiet inputs.
  task automatic do_reset();
    tick();
    clear_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // 1: reset with every request asserted
    rst          = 1'b0;
    stallreq_id  = 1'b1;
    stallreq_ex  = 1'b1;
    stallreq_mem = 1'b1;
    flush_req    = 1'b1;
    flush_pc     = 32'hDEAD_BEEF;
    #3;
    check("rst_stall", {26'd0, a_stall}, 32'd0);
    check("rst_flush", {31'd0, a_flush}, 32'd0);
    check("rst_new_pc", a_new_pc, 32'd0);
    check("rst_cycles", a_cyc, 32'd0);
    check("rst_timeout", {31'd0, a_tmo}, 32'd0);
    tick();
    check("rst_hold_stall", {26'd0, a_stall}, 32'd0);
    check("rst_hold_cycles", a_cyc, 32'd0);
    check("rst_hold_flush", {31'd0, b_flush}, 32'd0);

    // 2: priority decode, same cycle
    do_reset();
    tick();
    stallreq_id = 1'b1;
    stallreq_ex = 1'b1;
    #1;
    check("prio_id_ex", {26'd0, a_stall}, 32'h0000_000F);
    stallreq_mem = 1'b1;
    #1;
    check("prio_mem", {26'd0, a_stall}, 32'h0000_001F);
    tick();
    check("prio_cycles1", a_cyc, 32'd1);
    stallreq_mem = 1'b0;
    stallreq_ex  = 1'b0;
    #1;
    check("prio_id_only", {26'd0, a_stall}, 32'h0000_0007);
    tick();
    check("prio_cycles2", a_cyc, 32'd2);
    stallreq_id = 1'b0;
    #1;
    check("prio_none", {26'd0, a_stall}, 32'd0);
    tick();
    check("prio_cycles_hold", a_cyc, 32'd2);

    // 3: single flush with simultaneous EX stall
    do_reset();
    tick();
    stallreq_ex = 1'b1;
    flush_req   = 1'b1;
    flush_pc    = 32'h0000_0020;
    #1;
    check("fl_same_cycle_stall", {26'd0, a_stall}, 32'h0000_000F);
    check("fl_not_yet", {31'd0, a_flush}, 32'd0);
    tick();
    flush_req = 1'b0;
    flush_pc  = 32'h0000_0099;
    #1;
    check("fl_flush_hi", {31'd0, a_flush}, 32'd1);
    check("fl_new_pc", a_new_pc, 32'h0000_0020);
    check("fl_stall_forced0", {26'd0, a_stall}, 32'd0);
    tick();
    check("fl_flush_lo", {31'd0, a_flush}, 32'd0);
    check("fl_stall_back", {26'd0, a_stall}, 32'h0000_000F);
    check("fl_new_pc_kept", a_new_pc, 32'h0000_0020);
    check("fl_cycles", a_cyc, 32'd1);
    stallreq_ex = 1'b0;

    // 4: flush request during flush (FLUSH_CYC=3 on dut_b)
    do_reset();
    tick();
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0020;
    tick();
    flush_pc = 32'h0000_0040;
    #1;
    check("ff_b_cyc1", {31'd0, b_flush}, 32'd1);
    check("ff_b_pc1", b_new_pc, 32'h0000_0020);
    tick();
    flush_req = 1'b0;
    flush_pc  = 32'd0;
    #1;
    check("ff_b_cyc2", {31'd0, b_flush}, 32'd1);
    check("ff_b_pc2", b_new_pc, 32'h0000_0020);
    check("ff_a_no_ext", {31'd0, a_flush}, 32'd0);
    check("ff_a_pc", a_new_pc, 32'h0000_0020);
    tick();
    check("ff_b_cyc3", {31'd0, b_flush}, 32'd1);
    check("ff_b_pc3", b_new_pc, 32'h0000_0020);
    tick();
    check("ff_b_done", {31'd0, b_flush}, 32'd0);

    // 5: stall counter and watchdog, 7 on / 1 off / 8 on
    do_reset();
    tick();
    stallreq_ex = 1'b1;
    repeat (7) tick();
    check("wd_cycles7", a_cyc, 32'd7);
    check("wd_tmo_run1", {31'd0, a_tmo}, 32'd0);
    stallreq_ex = 1'b0;
    tick();
    check("wd_gap_cycles", a_cyc, 32'd7);
    check("wd_gap_tmo", {31'd0, a_tmo}, 32'd0);
    stallreq_ex = 1'b1;
    repeat (7) tick();
    check("wd_run2_7_tmo", {31'd0, a_tmo}, 32'd0);
    check("wd_run2_7_cycles", a_cyc, 32'd14);
    tick();
    check("wd_run2_8_tmo", {31'd0, a_tmo}, 32'd1);
    check("wd_run2_8_b_tmo", {31'd0, b_tmo}, 32'd1);
    check("wd_cycles15", a_cyc, 32'd15);
    stallreq_ex = 1'b0;
    repeat (2) tick();
    check("wd_sticky", {31'd0, a_tmo}, 32'd1);
    check("wd_cycles_final", a_cyc, 32'd15);

    // 6: asynchronous reset in the middle of a flush
    do_reset();
    tick();
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0020;
    tick();
    flush_req = 1'b0;
    check("ar_pre_flush", {31'd0, a_flush}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_flush_a", {31'd0, a_flush}, 32'd0);
    check("ar_pc_a", a_new_pc, 32'd0);
    check("ar_flush_b", {31'd0, b_flush}, 32'd0);
    check("ar_pc_b", b_new_pc, 32'd0);
    rst = 1'b1;
    tick();
    stallreq_ex = 1'b1;
    flush_req   = 1'b1;
    flush_pc    = 32'h0000_0020;
    #1;
    check("ar_re_stall", {26'd0, a_stall}, 32'h0000_000F);
    tick();
    flush_req = 1'b0;
    check("ar_re_flush", {31'd0, a_flush}, 32'd1);
    check("ar_re_pc", a_new_pc, 32'h0000_0020);
    check("ar_re_stall0", {26'd0, a_stall}, 32'd0);
    tick();
    check("ar_re_done", {31'd0, a_flush}, 32'd0);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
